// File: rtl/heartbeat_gen_pkg.sv
// Shared definitions for the heartbeat generator: FSM encoding,
// retry default, counter widths and a saturating increment helper.
package heartbeat_gen_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_REQ   = 2'd2,
    S_ERROR = 2'd3
  } hb_state_e;

  localparam int HB_MAX_RETRY = 3;
  localparam int HB_CNT_W     = 32;
  localparam int HB_STATS_W   = 16;

  function automatic logic [HB_STATS_W-1:0] sat_inc(
    input logic [HB_STATS_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/hb_cycle_counter.sv
// Clear/enable cycle counter with a ">= limit" compare on the next count.
// Ports: clk, rst (sync), clr, en, limit[31:0] in; hit out.
module hb_cycle_counter
  import heartbeat_gen_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clr,
  input  logic                en,
  input  logic [HB_CNT_W-1:0] limit,
  output logic                hit
);

  logic [HB_CNT_W-1:0] count;
  logic [HB_CNT_W-1:0] lim;
  logic [HB_CNT_W:0]   next_cnt;

  // A zero limit behaves as one so the owner always waits a cycle.
  assign lim      = (limit == '0) ? HB_CNT_W'(1) : limit;
  // Compare the count this cycle will produce, so the owner can
  // act on the same edge the limit is reached. Extra bit avoids wrap.
  assign next_cnt = {1'b0, count} + (HB_CNT_W+1)'(1);
  assign hit      = next_cnt >= {1'b0, lim};

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/heartbeat_gen.sv
// Periodic heartbeat requester with ack timeout, retry and sticky error.
// Ports: clk, rst (sync, high), en, period, ack_limit, hb_ack in;
// hb_req, hb_seq, hb_err, retry_cnt out. HEARTBEAT_STATS_EN adds
// sent_cnt / fail_cnt saturating statistics outputs.
module heartbeat_gen
  import heartbeat_gen_pkg::*;
#(
  parameter int MAX_RETRY = HB_MAX_RETRY,
  parameter int SEQ_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic [HB_CNT_W-1:0]   period,
  input  logic [HB_CNT_W-1:0]   ack_limit,
  input  logic                  hb_ack,
  output logic                  hb_req,
  output logic [SEQ_W-1:0]      hb_seq,
  output logic                  hb_err,
  output logic [1:0]            retry_cnt
`ifdef HEARTBEAT_STATS_EN
  ,
  output logic [HB_STATS_W-1:0] sent_cnt,
  output logic [HB_STATS_W-1:0] fail_cnt
`endif
);

  hb_state_e  state_q, state_d;
  logic       req_d, err_d;
  logic [SEQ_W-1:0] seq_d;
  logic [31:0] tries_q, tries_d, tries_inc;
  logic [1:0] retry_d;
  logic       p_clr, p_en, p_hit;
  logic       a_clr, a_en, a_hit;

  hb_cycle_counter u_period (
    .clk   (clk),
    .rst   (rst),
    .clr   (p_clr),
    .en    (p_en),
    .limit (period),
    .hit   (p_hit)
  );

  hb_cycle_counter u_ack (
    .clk   (clk),
    .rst   (rst),
    .clr   (a_clr),
    .en    (a_en),
    .limit (ack_limit),
    .hit   (a_hit)
  );

  assign tries_inc = tries_q + 32'd1;

  always_comb begin
    state_d = state_q;
    req_d   = 1'b0;
    err_d   = 1'b0;
    seq_d   = hb_seq;
    tries_d = tries_q;
    p_clr   = 1'b1;
    p_en    = 1'b0;
    a_clr   = 1'b1;
    a_en    = 1'b0;
    if (!en) begin
      state_d = S_IDLE;
      tries_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          state_d = S_COUNT;
          tries_d = '0;
        end
        S_COUNT: begin
          p_clr = 1'b0;
          p_en  = 1'b1;
          if (p_hit) begin
            state_d = S_REQ;
            req_d   = 1'b1;
          end
        end
        S_REQ: begin
          a_clr = 1'b0;
          req_d = 1'b1;
          // Ack beats a timeout landing on the same cycle.
          if (hb_ack) begin
            state_d = S_COUNT;
            req_d   = 1'b0;
            seq_d   = hb_seq + 1'b1;
            tries_d = '0;
          end else begin
            a_en = 1'b1;
            if (a_hit) begin
              req_d   = 1'b0;
              tries_d = tries_inc;
              if (tries_inc < 32'(MAX_RETRY)) begin
                state_d = S_COUNT;
              end else begin
                state_d = S_ERROR;
                err_d   = 1'b1;
              end
            end
          end
        end
        S_ERROR: begin
          err_d = 1'b1;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    retry_d = (tries_d > 32'd3) ? 2'd3 : tries_d[1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      hb_req    <= 1'b0;
      hb_err    <= 1'b0;
      hb_seq    <= '0;
      tries_q   <= '0;
      retry_cnt <= 2'd0;
    end else begin
      state_q   <= state_d;
      hb_req    <= req_d;
      hb_err    <= err_d;
      hb_seq    <= seq_d;
      tries_q   <= tries_d;
      retry_cnt <= retry_d;
    end
  end

`ifdef HEARTBEAT_STATS_EN
  logic [HB_STATS_W-1:0] sent_q, fail_q;
  logic ack_ev, to_ev;

  assign ack_ev = en && (state_q == S_REQ) && hb_ack;
  assign to_ev  = en && (state_q == S_REQ) && !hb_ack && a_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      sent_q <= '0;
      fail_q <= '0;
    end else begin
      if (ack_ev) sent_q <= sat_inc(sent_q);
      if (to_ev)  fail_q <= sat_inc(fail_q);
    end
  end

  assign sent_cnt = sent_q;
  assign fail_cnt = fail_q;
`else
  // No statistics counters in this build.
`endif

endmodule
